adder_16: RTL and testbench



---
 rtl/adder_16_if.sv | 25 ++
 rtl/adder_16.sv | 76 +++++++
 tb/tb_adder_16.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/adder_16_if.sv
// Operand/result bundle for adder_16: the master drives operands and carry-in,
// the slave (the adder) returns the registered sum and carry-out.
interface adder_16_if;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;

    modport master (
        output a,
        output b,
        output cin,
        input  s,
        input  cout
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output s,
        output cout
    );
endinterface : adder_16_if

// File: rtl/adder_16.sv
// Registered 16-bit adder with carry-in/carry-out built from four 4-bit
// carry-lookahead groups and a second-level lookahead unit.
module adder_16 (
    input  logic       clk,
    input  logic       rst,
    adder_16_if.slave  bus
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;
    logic [15:0] w_c;
    logic [15:0] w_sum;

    logic [15:0] r_s;
    logic        r_cout;

    assign w_g = bus.a & bus.b;
    assign w_p = bus.a ^ bus.b;

    // Group generate/propagate, then per-bit carries from the group carry-in.
    for (genvar k = 0; k < 4; k++) begin : g_group
        localparam int B = 4 * k;

        assign w_gg[k] = w_g[B+3]
                       | (w_p[B+3] & w_g[B+2])
                       | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                       | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
        assign w_gp[k] = &w_p[B+3:B];

        assign w_c[B]   = w_gc[k];
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
        assign w_c[B+2] = w_g[B+1]
                        | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_gc[k]);
        assign w_c[B+3] = w_g[B+2]
                        | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);
    end

    // Second-level lookahead: c4, c8, c12 and carry-out all flattened from cin.
    assign w_gc[0] = bus.cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & bus.cin);
    assign w_gc[2] = w_gg[1]
                   | (w_gp[1] & w_gg[0])
                   | (w_gp[1] & w_gp[0] & bus.cin);
    assign w_gc[3] = w_gg[2]
                   | (w_gp[2] & w_gg[1])
                   | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & bus.cin);
    assign w_gc[4] = w_gg[3]
                   | (w_gp[3] & w_gg[2])
                   | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & bus.cin);

    assign w_sum = w_p ^ w_c;

    // NOTE: non-blocking assignments keep every register update simultaneous at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= 16'd0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_gc[4];
        end
    end

    assign bus.s    = r_s;
    assign bus.cout = r_cout;

endmodule : adder_16

// File: tb/tb_adder_16.sv
// Directed and randomized checks of adder_16: reset, carries across group
// boundaries, wrap, one-cycle latency, hold between edges and mid-stream reset.
module tb_adder_16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    adder_16_if bus ();

    adder_16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive operands just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic c);
        bus.a   = a;
        bus.b   = b;
        bus.cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(16'hFFFF, 16'hFFFF, 1'b1);
            checks++;
            if ({bus.cout, bus.s} !== 17'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d] got %h want %h", i, {bus.cout, bus.s}, 17'h0);
            end
        end
        rst = 1'b0;
        step(16'hFFFF, 16'hFFFF, 1'b1);
        checks++;
        if ({bus.cout, bus.s} !== 17'h1FFFF) begin
            errors++;
            $display("FAIL reset_release got %h want %h", {bus.cout, bus.s}, 17'h1FFFF);
        end
    endtask

    task automatic test_basic();
        logic [15:0] va [4] = '{16'd15, 16'd243, 16'd243, 16'd243};
        logic [15:0] vb [4] = '{16'd12, 16'd12,  16'd12,  16'd11};
        logic        vc [4] = '{1'b0,   1'b0,    1'b1,    1'b1};
        logic [16:0] ve [4] = '{17'd27, 17'd255, 17'd256, 17'd255};
        for (int i = 0; i < 4; i++) begin
            step(va[i], vb[i], vc[i]);
            checks++;
            if ({bus.cout, bus.s} !== ve[i]) begin
                errors++;
                $display("FAIL basic[%0d] got %0d want %0d", i, {bus.cout, bus.s}, ve[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] va [5] = '{16'd65533, 16'd65533, 16'd65533, 16'hFFFF, 16'h8000};
        logic [15:0] vb [5] = '{16'd1,     16'd2,     16'd2,     16'h0000, 16'h8000};
        logic        vc [5] = '{1'b1,      1'b1,      1'b0,      1'b1,     1'b0};
        logic [16:0] ve [5] = '{17'h0FFFF, 17'h10000, 17'h0FFFF, 17'h10000, 17'h10000};
        for (int i = 0; i < 5; i++) begin
            step(va[i], vb[i], vc[i]);
            checks++;
            if ({bus.cout, bus.s} !== ve[i]) begin
                errors++;
                $display("FAIL wrap[%0d] got %h want %h", i, {bus.cout, bus.s}, ve[i]);
            end
        end
    endtask

    task automatic test_hold();
        step(16'd1, 16'd2, 1'b0);
        checks++;
        if ({bus.cout, bus.s} !== 17'd3) begin
            errors++;
            $display("FAIL hold_first got %0d want %0d", {bus.cout, bus.s}, 17'd3);
        end
        bus.a   = 16'd100;
        bus.b   = 16'd200;
        bus.cin = 1'b1;
        #3;
        checks++;
        if ({bus.cout, bus.s} !== 17'd3) begin
            errors++;
            $display("FAIL hold_midcycle got %0d want %0d", {bus.cout, bus.s}, 17'd3);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.cout, bus.s} !== 17'd301) begin
            errors++;
            $display("FAIL hold_next_edge got %0d want %0d", {bus.cout, bus.s}, 17'd301);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [16:0] exp;
        int          shown = 0;
        for (int i = 0; i < 10000; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            c   = 1'($urandom);
            rst = (i == 5000);
            exp = rst ? 17'h0 : ({1'b0, a} + {1'b0, b} + {16'd0, c});
            step(a, b, c);
            checks++;
            if ({bus.cout, bus.s} !== exp) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random[%0d] a=%h b=%h cin=%b rst=%b got %h want %h",
                             i, a, b, c, rst, {bus.cout, bus.s}, exp);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        bus.a   = 16'h0;
        bus.b   = 16'h0;
        bus.cin = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_wrap();
        test_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adder_16
